// File: rtl/arb_pkg.sv
// Shared definitions for the bus arbiter: state encoding, default bus widths
// and the sizing helper for the debug beat counter.
package arb_pkg;

    // Default bus geometry of the CPU memory bus
    localparam int DEF_AW = 13;
    localparam int DEF_DW = 8;

    // Arbiter state encoding (3-bit)
    localparam logic [2:0] ST_RUN    = 3'd0;
    localparam logic [2:0] ST_DRAIN  = 3'd1;
    localparam logic [2:0] ST_DBG    = 3'd2;
    localparam logic [2:0] ST_HALTED = 3'd3;
    localparam logic [2:0] ST_RESUME = 3'd4;

    typedef enum logic [2:0] {
        S_RUN    = ST_RUN,
        S_DRAIN  = ST_DRAIN,
        S_DBG    = ST_DBG,
        S_HALTED = ST_HALTED,
        S_RESUME = ST_RESUME
    } arb_state_t;

    // Bits needed to count from 0 up to and including max_burst
    function automatic int cnt_width(input int max_burst);
        int w;
        w = 1;
        while ((1 << w) <= max_burst) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bus_mux.sv
// Combinational owner-select for the shared memory bus. The arbiter state
// decides who drives mem_*; debug beats are granted here.
module bus_mux
    import arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  arb_state_t    state,
    input  logic          resume,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata
);

    logic gnt_next;

    // Select bus owner; strobes stay low unless the owner is actively driving
    always_comb begin
        gnt_next  = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        case (state)
            S_RUN, S_DRAIN: begin
                mem_rd    = cpu_rd;
                mem_wr    = cpu_wr;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            S_DBG: begin
                gnt_next = dbg_req;
            end
            S_HALTED: begin
                // A resume pulse takes precedence: leave without a grant
                gnt_next = dbg_req & ~resume;
            end
            default: begin
                gnt_next = 1'b0;
            end
        endcase
        if (gnt_next) begin
            mem_rd = ~dbg_we;
            mem_wr = dbg_we;
        end
        dbg_gnt = gnt_next;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the CPU memory bus between the core and a debug/loader master.
// The core is parked only at instruction boundaries (cpu_inst_end), held
// after HLT until resume, and always runs one full instruction between
// debug bursts because every return to RUN passes through RESUME.
module bus_arbiter
    import arb_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          cpu_ena,
    input  logic          cpu_inst_end,
    input  logic          cpu_halt,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    input  logic          resume,
    output logic          halted,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = cnt_width(MAX_BURST);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    arb_state_t    state_reg;
    logic [CW-1:0] beat_cnt_reg;
    logic          rvalid_reg;
    logic [DW-1:0] rdata_reg;

    // Owner select and grant generation
    bus_mux #(
        .AW(AW),
        .DW(DW)
    ) u_bus_mux (
        .state     (state_reg),
        .resume    (resume),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_gnt   (dbg_gnt),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    // Arbitration FSM and debug beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_RESUME;
            beat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_RUN: begin
                    if (cpu_halt) begin
                        state_reg <= S_HALTED;
                    end else if (dbg_req) begin
                        if (cpu_inst_end) begin
                            state_reg    <= S_DBG;
                            beat_cnt_reg <= '0;
                        end else begin
                            state_reg <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (cpu_halt) begin
                        state_reg <= S_HALTED;
                    end else if (cpu_inst_end) begin
                        state_reg    <= S_DBG;
                        beat_cnt_reg <= '0;
                    end else if (!dbg_req) begin
                        state_reg <= S_RUN;
                    end
                end
                S_DBG: begin
                    if (!dbg_gnt) begin
                        state_reg <= S_RESUME;
                    end else begin
                        beat_cnt_reg <= beat_cnt_reg + CW'(1);
                        if (beat_cnt_reg == LAST_BEAT) begin
                            state_reg <= S_RESUME;
                        end
                    end
                end
                S_HALTED: begin
                    if (resume) begin
                        state_reg <= S_RESUME;
                    end
                end
                S_RESUME: begin
                    state_reg <= S_RUN;
                end
                default: begin
                    state_reg <= S_RESUME;
                end
            endcase
        end
    end

    // Capture debug read data at the granting edge; valid for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= dbg_gnt & ~dbg_we;
            if (dbg_gnt && !dbg_we) begin
                rdata_reg <= mem_rdata;
            end
        end
    end

    assign cpu_ena    = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign halted     = (state_reg == S_HALTED);
    assign dbg_rvalid = rvalid_reg;
    assign dbg_rdata  = rdata_reg;
    assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_bus_arbiter;

    localparam int AW        = 13;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_ena;
    logic          cpu_inst_end;
    logic          cpu_halt;
    logic          cpu_rd;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          resume;
    logic          halted;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    bus_arbiter #(
        .AW(AW),
        .DW(DW),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_ena      (cpu_ena),
        .cpu_inst_end (cpu_inst_end),
        .cpu_halt     (cpu_halt),
        .cpu_rd       (cpu_rd),
        .cpu_wr       (cpu_wr),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .dbg_req      (dbg_req),
        .dbg_we       (dbg_we),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .dbg_gnt      (dbg_gnt),
        .dbg_rvalid   (dbg_rvalid),
        .dbg_rdata    (dbg_rdata),
        .resume       (resume),
        .halted       (halted),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Who may use the bus: the core (normally or while a debug request waits
    // for the instruction to end), a debug burst, a halted core, or the one
    // cycle gap before the core restarts.
    typedef enum int {M_CORE, M_WAIT, M_BURST, M_HALT, M_GAP} mode_t;
    mode_t         mode, mode_nx;
    int            beats_left, beats_left_nx;
    logic          m_rvalid, m_rvalid_nx;
    logic [DW-1:0] m_rdata, m_rdata_nx;
    logic          exp_gnt;

    task automatic model_reset();
        mode       = M_GAP;
        beats_left = 0;
        m_rvalid   = 1'b0;
        m_rdata    = '0;
    endtask

    task automatic model_check();
        logic core_owns;
        logic exp_rd, exp_wr;
        core_owns = (mode == M_CORE) || (mode == M_WAIT);
        exp_gnt   = dbg_req && ((mode == M_BURST) || (mode == M_HALT && !resume));
        exp_rd    = exp_gnt ? !dbg_we : (core_owns && cpu_rd);
        exp_wr    = exp_gnt ? dbg_we  : (core_owns && cpu_wr);
        chk("model.cpu_ena", cpu_ena, core_owns);
        chk("model.halted", halted, mode == M_HALT);
        chk("model.dbg_gnt", dbg_gnt, exp_gnt);
        chk("model.mem_rd", mem_rd, exp_rd);
        chk("model.mem_wr", mem_wr, exp_wr);
        chk("model.dbg_rvalid", dbg_rvalid, m_rvalid);
        chk("model.dbg_rdata", dbg_rdata, m_rdata);
        chk("model.cpu_rdata", cpu_rdata, mem_rdata);
        if (exp_gnt) begin
            chk("model.mem_addr_dbg", mem_addr, dbg_addr);
            if (dbg_we) chk("model.mem_wdata_dbg", mem_wdata, dbg_wdata);
        end else if (core_owns) begin
            chk("model.mem_addr_cpu", mem_addr, cpu_addr);
            chk("model.mem_wdata_cpu", mem_wdata, cpu_wdata);
        end
        // what happens at the coming edge
        mode_nx       = mode;
        beats_left_nx = beats_left;
        case (mode)
            M_CORE: begin
                if (cpu_halt) mode_nx = M_HALT;
                else if (dbg_req) begin
                    mode_nx       = cpu_inst_end ? M_BURST : M_WAIT;
                    beats_left_nx = MAX_BURST;
                end
            end
            M_WAIT: begin
                if (cpu_halt) mode_nx = M_HALT;
                else if (cpu_inst_end) begin
                    mode_nx       = M_BURST;
                    beats_left_nx = MAX_BURST;
                end else if (!dbg_req) mode_nx = M_CORE;
            end
            M_BURST: begin
                if (!dbg_req) mode_nx = M_GAP;
                else begin
                    beats_left_nx = beats_left - 1;
                    if (beats_left_nx == 0) mode_nx = M_GAP;
                end
            end
            M_HALT:  if (resume) mode_nx = M_GAP;
            default: mode_nx = M_CORE;
        endcase
        m_rvalid_nx = exp_gnt && !dbg_we;
        m_rdata_nx  = m_rvalid_nx ? mem_rdata : m_rdata;
    endtask

    task automatic model_commit();
        mode       = mode_nx;
        beats_left = beats_left_nx;
        m_rvalid   = m_rvalid_nx;
        m_rdata    = m_rdata_nx;
    endtask

    // sample mid-cycle, then step past the rising edge
    task automatic half_a();
        @(negedge clk);
        #1;
        model_check();
    endtask

    task automatic half_b();
        @(posedge clk);
        #1;
        model_commit();
    endtask

    task automatic step();
        half_a();
        half_b();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic req, we, ie, halt, res;
        logic ena, gnt, rd, wr, hlt;
    } vec_t;

    vec_t vecs[25];

    task automatic fill_vecs();
        //          req we ie hl rs | ena gnt rd wr hlt
        vecs[0]  = '{0, 1, 0, 0, 0,   1, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 0, 0, 0,   1, 0, 0, 0, 0};
        vecs[2]  = '{1, 1, 0, 0, 0,   1, 0, 0, 0, 0};
        vecs[3]  = '{1, 1, 1, 0, 0,   1, 0, 0, 0, 0};
        vecs[4]  = '{1, 1, 0, 0, 0,   0, 1, 0, 1, 0};
        vecs[5]  = '{0, 1, 0, 0, 0,   0, 0, 0, 0, 0};
        vecs[6]  = '{0, 1, 0, 0, 0,   0, 0, 0, 0, 0};
        vecs[7]  = '{0, 1, 0, 0, 0,   1, 0, 0, 0, 0};
        vecs[8]  = '{1, 1, 1, 0, 0,   1, 0, 0, 0, 0};
        vecs[9]  = '{1, 1, 0, 0, 0,   0, 1, 0, 1, 0};
        vecs[10] = '{1, 1, 0, 0, 0,   0, 1, 0, 1, 0};
        vecs[11] = '{1, 1, 0, 0, 0,   0, 1, 0, 1, 0};
        vecs[12] = '{1, 1, 0, 0, 0,   0, 1, 0, 1, 0};
        vecs[13] = '{1, 1, 0, 0, 0,   0, 0, 0, 0, 0};
        vecs[14] = '{1, 1, 0, 0, 0,   1, 0, 0, 0, 0};
        vecs[15] = '{1, 1, 1, 0, 0,   1, 0, 0, 0, 0};
        vecs[16] = '{1, 1, 0, 0, 0,   0, 1, 0, 1, 0};
        vecs[17] = '{0, 1, 0, 0, 0,   0, 0, 0, 0, 0};
        vecs[18] = '{0, 1, 0, 0, 0,   0, 0, 0, 0, 0};
        vecs[19] = '{0, 1, 0, 0, 0,   1, 0, 0, 0, 0};
        vecs[20] = '{0, 1, 0, 1, 0,   1, 0, 0, 0, 0};
        vecs[21] = '{1, 0, 0, 0, 0,   0, 1, 1, 0, 1};
        vecs[22] = '{1, 0, 0, 0, 1,   0, 0, 0, 0, 1};
        vecs[23] = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        vecs[24] = '{0, 0, 0, 0, 0,   1, 0, 0, 0, 0};
    endtask

    task automatic clear_inputs();
        cpu_inst_end = 1'b0;
        cpu_halt     = 1'b0;
        cpu_rd       = 1'b0;
        cpu_wr       = 1'b0;
        cpu_addr     = '0;
        cpu_wdata    = '0;
        dbg_req      = 1'b0;
        dbg_we       = 1'b0;
        dbg_addr     = '0;
        dbg_wdata    = '0;
        resume       = 1'b0;
        mem_rdata    = '0;
    endtask

    logic [DW-1:0] prev_data;
    logic          last_gnt;

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        dbg_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // reset values, with a request present so the grant check can bite
        chk("reset.cpu_ena", cpu_ena, 1'b0);
        chk("reset.dbg_gnt", dbg_gnt, 1'b0);
        chk("reset.mem_rd", mem_rd, 1'b0);
        chk("reset.mem_wr", mem_wr, 1'b0);
        chk("reset.dbg_rvalid", dbg_rvalid, 1'b0);
        chk("reset.dbg_rdata", dbg_rdata, 8'h00);
        chk("reset.halted", halted, 1'b0);
        dbg_req = 1'b0;
        rst_n   = 1'b1;
        half_a();
        chk("startup.cpu_ena_low", cpu_ena, 1'b0);
        half_b();

        // ---- table: mid-instruction write, full burst, halt/resume race ----
        fill_vecs();
        dbg_addr  = 13'h1A5;
        dbg_wdata = 8'h3C;
        for (int i = 0; i < 25; i++) begin
            dbg_req      = vecs[i].req;
            dbg_we       = vecs[i].we;
            cpu_inst_end = vecs[i].ie;
            cpu_halt     = vecs[i].halt;
            resume       = vecs[i].res;
            mem_rdata    = 8'(8'h40 + i);
            half_a();
            $display("vec %0d: req=%b we=%b ie=%b halt=%b res=%b -> ena=%b gnt=%b rd=%b wr=%b halted=%b",
                     i, dbg_req, dbg_we, cpu_inst_end, cpu_halt, resume,
                     cpu_ena, dbg_gnt, mem_rd, mem_wr, halted);
            chk($sformatf("vec%0d.cpu_ena", i), cpu_ena, vecs[i].ena);
            chk($sformatf("vec%0d.dbg_gnt", i), dbg_gnt, vecs[i].gnt);
            chk($sformatf("vec%0d.mem_rd", i), mem_rd, vecs[i].rd);
            chk($sformatf("vec%0d.mem_wr", i), mem_wr, vecs[i].wr);
            chk($sformatf("vec%0d.halted", i), halted, vecs[i].hlt);
            if (vecs[i].wr) begin
                chk($sformatf("vec%0d.mem_addr", i), mem_addr, 13'h1A5);
                chk($sformatf("vec%0d.mem_wdata", i), mem_wdata, 8'h3C);
            end
            half_b();
        end
        clear_inputs();

        // ---- halt, then 10 back-to-back reads ----
        cpu_halt = 1'b1;
        step();
        cpu_halt = 1'b0;
        prev_data = '0;
        for (int i = 0; i < 10; i++) begin
            dbg_req   = 1'b1;
            dbg_we    = 1'b0;
            dbg_addr  = AW'(13'h100 + i * 3);
            mem_rdata = 8'($urandom);
            half_a();
            $display("halt read %0d: addr=%0h gnt=%b rvalid=%b rdata=%0h", i, dbg_addr, dbg_gnt, dbg_rvalid, dbg_rdata);
            chk("halt.halted", halted, 1'b1);
            chk("halt.cpu_ena", cpu_ena, 1'b0);
            chk("halt.read_gnt", dbg_gnt, 1'b1);
            chk("halt.read_addr", mem_addr, AW'(13'h100 + i * 3));
            if (i > 0) begin
                chk("halt.rvalid", dbg_rvalid, 1'b1);
                chk("halt.rdata", dbg_rdata, prev_data);
            end
            prev_data = mem_rdata;
            half_b();
        end
        dbg_req = 1'b0;
        half_a();
        chk("halt.last_rvalid", dbg_rvalid, 1'b1);
        chk("halt.last_rdata", dbg_rdata, prev_data);
        half_b();
        half_a();
        chk("halt.rvalid_drop", dbg_rvalid, 1'b0);
        half_b();
        resume = 1'b1;
        step();
        resume = 1'b0;
        half_a();
        chk("resume.gap_ena", cpu_ena, 1'b0);
        chk("resume.halted_clear", halted, 1'b0);
        half_b();
        half_a();
        chk("resume.run_ena", cpu_ena, 1'b1);
        half_b();

        // ---- asynchronous reset in the middle of a debug burst ----
        dbg_req      = 1'b1;
        dbg_we       = 1'b0;
        dbg_addr     = 13'h0AA;
        cpu_inst_end = 1'b1;
        mem_rdata    = 8'h5A;
        step();
        cpu_inst_end = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset mid-burst: ena=%b gnt=%b rvalid=%b rdata=%0h", cpu_ena, dbg_gnt, dbg_rvalid, dbg_rdata);
        chk("midrst.cpu_ena", cpu_ena, 1'b0);
        chk("midrst.dbg_gnt", dbg_gnt, 1'b0);
        chk("midrst.mem_rd", mem_rd, 1'b0);
        chk("midrst.mem_wr", mem_wr, 1'b0);
        chk("midrst.dbg_rvalid", dbg_rvalid, 1'b0);
        chk("midrst.dbg_rdata", dbg_rdata, 8'h00);
        chk("midrst.halted", halted, 1'b0);
        model_reset();
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        half_a();
        chk("midrst.restart_ena", cpu_ena, 1'b1);
        half_b();

        // ---- randomized run against the model ----
        last_gnt = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!dbg_req || last_gnt) begin
                dbg_req   = ($urandom_range(0, 2) != 0);
                dbg_we    = 1'($urandom);
                dbg_addr  = AW'($urandom);
                dbg_wdata = DW'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                dbg_req = 1'b0;
            end
            cpu_inst_end = ($urandom_range(0, 3) == 0);
            cpu_halt     = ($urandom_range(0, 49) == 0);
            resume       = (mode == M_HALT) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 19) == 0);
            cpu_rd       = 1'($urandom);
            cpu_wr       = 1'($urandom);
            cpu_addr     = AW'($urandom);
            cpu_wdata    = DW'($urandom);
            mem_rdata    = DW'($urandom);
            half_a();
            last_gnt = exp_gnt;
            half_b();
        end
        $display("random phase done: %0d cycles", 1500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
